// File: rtl/tileram_arbiter.sv
// tileram_arbiter
// Shares the single 2048x16 tile-pattern memory between the video pixel
// pipeline and CPU byte accesses.
// Video lookups always win and pass straight through to the memory port.
// CPU byte writes go into a 4-entry FIFO and retire in idle cycles.
// A CPU byte read waits until the FIFO is empty, so it sees every earlier write.
//
// Ports
//   clk, reset      : system clock, synchronous active-high reset
//   vid_req         : video owns the memory this cycle
//   vid_name/row    : video lookup address {name, row}
//   cpu_wr/cpu_rd   : one-cycle byte write / read strobes
//   cpu_addr        : byte address, [11:1] word, [0] lane (0 = high byte)
//   cpu_wdata       : write byte
//   cpu_wr_full     : write FIFO holds 4 entries
//   cpu_overflow    : sticky, a write was dropped because the FIFO was full
//   cpu_rd_busy     : read outstanding, new cpu_rd ignored
//   cpu_rdata       : last read byte, held until the next read completes
//   cpu_rd_valid    : one-cycle pulse when cpu_rdata updates
//   mem_*           : tile memory port; mem_rdata arrives one cycle after mem_addr
//   rd_state        : read state machine state, for observation
//
// Handshake: the CPU side has no ready signal. A write is taken when cpu_wr
// is high and cpu_wr_full is low, and is dropped otherwise. A read is taken
// when cpu_rd is high and cpu_rd_busy is low, and is ignored otherwise. Each
// accepted read completes with exactly one cpu_rd_valid pulse, unless a reset
// arrives first.
module tileram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [7:0]  vid_name,
  input  logic [2:0]  vid_row,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_wr_full,
  output logic        cpu_overflow,
  output logic        cpu_rd_busy,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rd_valid,
  output logic [10:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  rd_state
);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_PEND = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  // Write FIFO
  logic [11:0] fifo_addr [4];
  logic [7:0]  fifo_data [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        overflow_q;
  logic        wr_accept;

  // Read path
  rd_state_t   state_q;
  rd_state_t   state_d;
  logic [11:0] rd_addr_q;
  logic        rd_load;
  logic        rd_valid_q;
  logic [7:0]  rdata_q;

  // Grants
  logic        grant_wr;
  logic        grant_rd;
  logic [11:0] head_addr;
  logic [7:0]  head_data;

  // Space is judged on the count at the start of the cycle, so a pop in the
  // same cycle does not make room for a write.
  assign wr_accept = cpu_wr && (count != 3'd4);

  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // Video first, then the FIFO head, then a read once all writes have drained.
  // Reset blocks every CPU grant, so mem_we stays low during reset.
  assign grant_wr = !reset && !vid_req && (count != 3'd0);
  assign grant_rd = !reset && !vid_req && (count == 3'd0) && (state_q == RD_PEND);

  always_comb begin
    mem_addr  = {vid_name, vid_row};
    mem_we    = 1'b0;
    mem_wdata = {head_data, head_data};
    mem_wmask = 2'b00;
    if (grant_wr) begin
      mem_addr  = head_addr[11:1];
      mem_we    = 1'b1;
      mem_wmask = head_addr[0] ? 2'b01 : 2'b10;
    end else if (grant_rd) begin
      mem_addr = rd_addr_q[11:1];
    end
  end

  // FIFO storage needs no reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 2'd1;
      if (grant_wr)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, wr_accept} - {2'b00, grant_wr};
      if (cpu_wr && !wr_accept) overflow_q <= 1'b1;
    end
  end

  // Read state machine
  always_comb begin
    state_d = state_q;
    rd_load = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (cpu_rd && !cpu_rd_busy) begin
          state_d = RD_PEND;
          rd_load = 1'b1;
        end
      end
      RD_PEND: begin
        if (grant_rd) state_d = RD_DATA;
      end
      RD_DATA: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RD_IDLE;
      rd_addr_q  <= 12'h000;
      rd_valid_q <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      if (rd_load) rd_addr_q <= cpu_addr;
      // DATA is the cycle where mem_rdata holds the word addressed during PEND.
      rd_valid_q <= (state_q == RD_DATA);
      if (state_q == RD_DATA) begin
        rdata_q <= rd_addr_q[0] ? mem_rdata[7:0] : mem_rdata[15:8];
      end
    end
  end

  // Busy also covers the valid-pulse cycle, so a new read cannot overlap it.
  assign cpu_rd_busy  = (state_q != RD_IDLE) || rd_valid_q;
  assign cpu_rd_valid = rd_valid_q;
  assign cpu_rdata    = rdata_q;
  assign cpu_wr_full  = (count == 3'd4);
  assign cpu_overflow = overflow_q;
  assign rd_state     = state_q;

endmodule

// File: doc/tileram_arbiter.md
# tileram_arbiter

Shares the single 2048×16 tile-pattern memory between the video pixel pipeline and CPU byte accesses. Video lookups have absolute priority and pass through with zero added latency. CPU byte writes are queued in a 4-entry FIFO and retired into idle memory cycles. CPU byte reads are ordered after all earlier writes. The block sits between the CPU bus decoder, the video timing/name-fetch logic and the tile memory array.

## Interface
- Parameters: none (memory geometry fixed: 11-bit word address, 16-bit word, 2 bits/pixel, pixel 0 in bits 15:14).
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- vid_req  in  1  video needs the memory this cycle.
- vid_name  in  8  tile name for video lookup.
- vid_row  in  3  tile row for video lookup.
- cpu_wr  in  1  byte write strobe, one cycle per write.
- cpu_rd  in  1  byte read strobe, one cycle per read.
- cpu_addr  in  12  byte address: [11:1] word address, [0] lane (0 = bits 15:8, 1 = bits 7:0).
- cpu_wdata  in  8  write byte.
- cpu_wr_full  out  1  write FIFO holds 4 entries.
- cpu_overflow  out  1  sticky: a write arrived while full.
- cpu_rd_busy  out  1  a read is outstanding; new cpu_rd ignored.
- cpu_rdata  out  8  read byte, held until next read completes.
- cpu_rd_valid  out  1  one-cycle pulse, cpu_rdata updated.
- mem_addr  out  11  memory word address, sampled by memory at clock edge.
- mem_we  out  1  write enable.
- mem_wdata  out  16  write word, {byte, byte}.
- mem_wmask  out  2  lane enables: 2'b10 high byte, 2'b01 low byte.
- mem_rdata  in  16  memory read word, valid the cycle after its address was presented.

## Operation
- Grant priority per cycle, evaluated combinationally: (1) vid_req; (2) FIFO head write; (3) pending CPU read, only when FIFO is empty; (4) none.
- Video grant: mem_addr = {vid_name, vid_row}, mem_we = 0. The grant is pure pass-through.
- Write grant: mem_addr = head word address, mem_we = 1, mem_wdata = {b, b}, mem_wmask from lane bit. The head is popped at the end of the cycle.
- Read grant: mem_addr = pending word address, mem_we = 0. The lane is captured. In the next cycle the selected byte of mem_rdata is registered into cpu_rdata.
- No grant: mem_addr = {vid_name, vid_row}, mem_we = 0.
- mem_we is never asserted while vid_req = 1.
- FIFO: 4 entries of {addr[11:0], data[7:0]}, with 3-bit count.
  - cpu_wr is accepted iff count < 4 at the start of the cycle. A simultaneous pop does not free space in that cycle.
  - A write while full is dropped and sets cpu_overflow.
  - Pointers wrap modulo 4.
- Read state machine:
  - IDLE: cpu_rd && !cpu_rd_busy latches the address and goes to PEND.
  - PEND: waits for a read grant, then goes to DATA.
  - DATA: captures the byte and pulses cpu_rd_valid (registered, visible the next cycle), then returns to IDLE.
- cpu_rd_busy = 1 whenever state ≠ IDLE, and also during the cpu_rd_valid cycle.
- Simultaneous cpu_wr and cpu_rd: the write is enqueued first. The read waits for it, so it returns the new data if the addresses match.
- Reset (also mid-operation):
  - FIFO cleared and state goes to IDLE. A pending read is dropped with no valid pulse.
  - Outputs: cpu_wr_full = 0, cpu_overflow = 0, cpu_rd_busy = 0, cpu_rdata = 8'h00, cpu_rd_valid = 0, mem_we = 0.

## Timing
- Video: zero added latency. Address in cycle N, memory data in N+1.
- Write: accepted in cycle N. Earliest mem_we is N+1 (FIFO empty, vid_req low). It is stalled one cycle for every cycle vid_req is high.
- Read, best case:
  - Accepted in N, granted in N+1, mem_rdata in N+2.
  - cpu_rd_valid and the new cpu_rdata appear in N+3. cpu_rd_busy falls in N+4.
- A continuous vid_req starves the CPU indefinitely; this is by design, since video blanking guarantees idle cycles.
- cpu_wr_full and cpu_overflow are registered, updated at the edge after the causing event.

## Test plan
- Reset, then an idle cycle → all outputs at reset values; mem_addr follows {vid_name, vid_row}.
- vid_req = 0, write addr 12'h005, data 8'hA5 → next cycle mem_addr = 11'h002, mem_we = 1, mem_wdata = 16'hA5A5, mem_wmask = 2'b01.
- vid_req held high 10 cycles while 5 writes issued → first 4 queued, cpu_wr_full = 1, 5th dropped, cpu_overflow = 1, no mem_we during vid_req. Writes then retire in order, one per cycle, after vid_req falls.
- Write 8'h3C to 12'h010 and read 12'h010 in the same cycle, vid_req = 0 → write retires first; cpu_rd_valid pulses with cpu_rdata = 8'h3C.
- Read pending in PEND, reset asserted → no cpu_rd_valid pulse; cpu_rd_busy = 0 the cycle after reset.
- Memory model returns 16'hBEEF for word 11'h7FF, read byte 12'hFFE → cpu_rdata = 8'hBE in N+3. A second read of 12'hFFF gives 8'hEF.
